// File: rtl/noise_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noise_pkg
// Description : Shared types and constants for the noise scheduler slice.
//               Holds the scheduler state encoding, the noise mode encoding,
//               the LFSR tap constant and the helper that maps a mode plus
//               LFSR bits to the number of bits flipped in a codeword.
// Revision    : 1.0 - initial release
// ============================================================================
package noise_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GEN     = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } ns_state_t;

    typedef enum logic [1:0] {
        NM_NONE   = 2'd0,
        NM_SINGLE = 2'd1,
        NM_DOUBLE = 2'd2,
        NM_RANDOM = 2'd3
    } noise_mode_t;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 on a left-shifting register
    // (register bits 15, 13, 12, 10 feed the new LSB).
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    // Number of set bits in the mask for one codeword. In random mode the
    // two selector bits give 0, 1 or 2 directly; the unused code 3 means 0.
    function automatic logic [1:0] bits_for_mode(input noise_mode_t mode,
                                                 input logic [1:0]  sel);
        logic [1:0] k;
        k = 2'd0;
        case (mode)
            NM_NONE:   k = 2'd0;
            NM_SINGLE: k = 2'd1;
            NM_DOUBLE: k = 2'd2;
            NM_RANDOM: k = (sel == 2'b11) ? 2'd0 : sel;
            default:   k = 2'd0;
        endcase
        return k;
    endfunction

endpackage : noise_pkg
`default_nettype wire

// File: rtl/noise_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : noise_lfsr
// Description : Fibonacci LFSR used to pick noise bit positions and counts.
//               Loads SEED on reset or load, advances one step on step.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous reset, active-low (value <= SEED)
//               load  - reload SEED (has priority over step)
//               step  - advance one position
//               value - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module noise_lfsr
    import noise_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    localparam logic [LFSR_W-1:0] c_taps = LFSR_W'(C_LFSR_TAPS);

    logic [LFSR_W-1:0] r_value;
    logic              w_feedback;

    assign w_feedback = ^(r_value & c_taps);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= SEED;
        end else if (load) begin
            r_value <= SEED;
        end else if (step) begin
            r_value <= {r_value[LFSR_W-2:0], w_feedback};
        end
    end

    assign value = r_value;

endmodule : noise_lfsr
`default_nettype wire

// File: rtl/noise_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : noise_scheduler
// Description : Builds a per-codeword noise mask with 0/1/2 set bits at
//               LFSR-chosen positions, presents it to the XOR noise adder
//               aligned with the encoder output, and counts words and
//               flipped bits over a configured batch.
// Ports       : clk, rst (sync, active-low)
//               start, abort              - batch control
//               cfg_mode, cfg_num_words   - batch config, latched on start
//               enc_valid / enc_ready     - encoder handshake
//               noise, noise_valid        - mask to noise adder
//               out_ready                 - downstream accept
//               busy, done                - status
//               words_sent, bits_flipped  - batch counters
// Revision    : 1.0 - initial release
// ============================================================================
module noise_scheduler
    import noise_pkg::*;
#(
    parameter int                DATA_WIDTH = 32,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            cfg_mode,
    input  logic [CNT_W-1:0]      cfg_num_words,
    input  logic                  enc_valid,
    output logic                  enc_ready,
    output logic [DATA_WIDTH-1:0] noise,
    output logic                  noise_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      words_sent,
    output logic [CNT_W-1:0]      bits_flipped
);

    localparam int c_pos_w = $clog2(DATA_WIDTH);

    ns_state_t             r_state;
    ns_state_t             w_state_next;
    noise_mode_t           r_mode;
    logic [CNT_W-1:0]      r_num_words;
    logic [CNT_W-1:0]      r_words_sent;
    logic [CNT_W-1:0]      r_bits_flipped;
    logic [DATA_WIDTH-1:0] r_noise;
    logic [1:0]            r_k;

    logic [LFSR_W-1:0]     w_lfsr;
    logic                  w_start_accept;
    logic                  w_transfer;
    logic                  w_last;
    logic [1:0]            w_gen_k;
    logic [c_pos_w-1:0]    w_p1;
    logic [c_pos_w-1:0]    w_p2_raw;
    logic [c_pos_w-1:0]    w_p2;
    logic [DATA_WIDTH-1:0] w_gen_mask;
    logic [CNT_W:0]        w_bits_sum;
    logic [CNT_W-1:0]      w_bits_sat;
    logic                  w_unused_lfsr;

    // abort beats a simultaneous start
    assign w_start_accept = (r_state == IDLE) && start && !abort;
    assign w_transfer     = noise_valid && out_ready;
    assign w_last         = ((r_words_sent + CNT_W'(1)) == r_num_words);

    noise_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (w_start_accept),
        .step   (r_state == GEN),
        .value  (w_lfsr)
    );

    // Only selected LFSR bits feed the mask; the reduction keeps the rest
    // visibly consumed.
    assign w_unused_lfsr = ^w_lfsr;

    // ---------------------------------------------------------------- mask
    assign w_gen_k  = bits_for_mode(r_mode, w_lfsr[15:14]);
    assign w_p1     = w_lfsr[c_pos_w-1:0];
    assign w_p2_raw = w_lfsr[8 +: c_pos_w];
    // A colliding second position moves up one bit (wrapping at the top)
    // so a double-error word always flips exactly two bits.
    assign w_p2     = (w_p2_raw == w_p1) ? (w_p1 + c_pos_w'(1)) : w_p2_raw;

    always_comb begin
        w_gen_mask = '0;
        if (w_gen_k != 2'd0) begin
            w_gen_mask[w_p1] = 1'b1;
        end
        if (w_gen_k == 2'd2) begin
            w_gen_mask[w_p2] = 1'b1;
        end
    end

    // Flipped-bit counter saturates at all-ones instead of wrapping.
    assign w_bits_sum = {1'b0, r_bits_flipped} + (CNT_W+1)'(r_k);
    assign w_bits_sat = w_bits_sum[CNT_W] ? {CNT_W{1'b1}} : w_bits_sum[CNT_W-1:0];

    // ------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_accept) begin
                    w_state_next = (cfg_num_words == '0) ? DONE : GEN;
                end
            end
            GEN: begin
                w_state_next = abort ? IDLE : PRESENT;
            end
            PRESENT: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_transfer) begin
                    w_state_next = w_last ? DONE : GEN;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        noise_valid = (r_state == PRESENT) && enc_valid;
        enc_ready   = (r_state == PRESENT) && enc_valid && out_ready;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode         <= NM_NONE;
            r_num_words    <= '0;
            r_words_sent   <= '0;
            r_bits_flipped <= '0;
            r_noise        <= '0;
            r_k            <= 2'd0;
        end else begin
            if (w_start_accept) begin
                r_mode         <= noise_mode_t'(cfg_mode);
                r_num_words    <= cfg_num_words;
                r_words_sent   <= '0;
                r_bits_flipped <= '0;
            end
            if (r_state == GEN) begin
                r_noise <= w_gen_mask;
                r_k     <= w_gen_k;
            end
            // A transfer coinciding with abort still counts.
            if (w_transfer) begin
                r_words_sent   <= r_words_sent + CNT_W'(1);
                r_bits_flipped <= w_bits_sat;
            end
        end
    end

    assign noise        = r_noise;
    assign words_sent   = r_words_sent;
    assign bits_flipped = r_bits_flipped;

endmodule : noise_scheduler
`default_nettype wire
